// File: rtl/nco_bank.sv
// nco_bank: multi-channel NCO, NCH phase accumulators swept one channel per cycle,
//   each producing a signed sine sample from a shared quarter-wave table.
// Latency: tick at T -> channel k sample on out_valid at T+2+k; sweep period NCH+2.
// Backpressure: none; a tick while busy is dropped and flagged on overrun the next cycle.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   cfg_we/cfg_ch/      centre frequency word write, always accepted; a write to
//   cfg_center            the channel currently updating takes effect next sweep
//   ctrl_in             NCH signed control words, channel k at [k*CTRL_W +: CTRL_W]
//   sync                clear all phases and cancel any sweep in progress
//   tick                start a sweep over all channels (when busy=0)
//   busy, overrun       sweep in progress / one-cycle pulse for a rejected tick
//   out_valid, out_ch,  sample strobe, channel, sine sample, phase-wrap flag;
//   out_sin, out_wrap     data outputs hold their last value between strobes
//   out_cos             cosine of the same phase, present only with NCO_COS_EN
//
// Optional feature: define NCO_COS_EN to add the out_cos port and its table lookup.
module nco_bank #(
  parameter int NCH     = 4,
  parameter int PHASE_W = 32,
  parameter int CTRL_W  = 16,
  parameter int GAIN_SH = 8,
  parameter int LUT_AW  = 8,
  parameter int OUT_W   = 12,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [PHASE_W-1:0]       cfg_center,
  input  logic [NCH*CTRL_W-1:0]    ctrl_in,
  input  logic                     sync,
  input  logic                     tick,
  output logic                     busy,
  output logic                     overrun,
  output logic                     out_valid,
  output logic [CH_W-1:0]          out_ch,
  output logic signed [OUT_W-1:0]  out_sin,
`ifdef NCO_COS_EN
  output logic signed [OUT_W-1:0]  out_cos,
`endif
  output logic                     out_wrap
);

  localparam int LUT_N = 2 ** LUT_AW;

  // Quarter-wave magnitude table, sampled at bin centres so that the mirrored
  // quadrants never repeat an endpoint value.
  function automatic logic [OUT_W-2:0] lut_val(input int j);
    real ang;
    real amp;
    ang = (3.14159265358979 / 2.0) * (real'(j) + 0.5) / real'(LUT_N);
    amp = real'((2 ** (OUT_W - 1)) - 1) * $sin(ang);
    return (OUT_W-1)'($rtoi(amp + 0.5));
  endfunction

  logic [OUT_W-2:0] lut_rom [LUT_N];
  for (genvar j = 0; j < LUT_N; j++) begin : g_lut
    localparam logic [OUT_W-2:0] LUT_V = lut_val(j);
    assign lut_rom[j] = LUT_V;
  end

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e                    state_q, state_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic                      overrun_q, overrun_d;
  logic [PHASE_W-1:0]        center_q [NCH];
  logic [PHASE_W-1:0]        phase_q  [NCH];

  logic                      out_valid_q, out_valid_d;
  logic [CH_W-1:0]           out_ch_q, out_ch_d;
  logic [OUT_W-1:0]          out_sin_q, out_sin_d;
  logic                      out_wrap_q, out_wrap_d;

  // Stage-1 datapath for the channel selected by ch_q.
  logic [PHASE_W-1:0]        cur_phase, cur_center, ctrl_ext, fcw;
  logic [CTRL_W-1:0]         cur_ctrl;
  logic [PHASE_W:0]          sum;
  logic [1:0]                quad;
  logic [LUT_AW-1:0]         idx;
  logic [OUT_W-1:0]          sin_val;
  logic                      running;

  assign running = (state_q == S_RUN);
  assign busy    = running | out_valid_q;

  always_comb begin
    cur_phase  = '0;
    cur_center = '0;
    cur_ctrl   = '0;
    for (int k = 0; k < NCH; k++) begin
      if (ch_q == CH_W'(k)) begin
        cur_phase  = phase_q[k];
        cur_center = center_q[k];
        cur_ctrl   = ctrl_in[k*CTRL_W +: CTRL_W];
      end
    end
  end

  assign ctrl_ext = PHASE_W'($signed(cur_ctrl));
  assign fcw      = cur_center + (ctrl_ext << GAIN_SH);
  assign sum      = {1'b0, cur_phase} + {1'b0, fcw};

  // The sample address comes from the phase before this update.
  assign quad = cur_phase[PHASE_W-1 -: 2];
  assign idx  = cur_phase[PHASE_W-3 -: LUT_AW];

  // Odd quadrants read the table mirrored; the upper half-cycle is negated.
  function automatic logic [OUT_W-1:0] quad_lookup(input logic [1:0] q,
                                                   input logic [OUT_W-2:0] mag);
    logic [OUT_W-1:0] m;
    m = {1'b0, mag};
    return q[1] ? -m : m;
  endfunction

  assign sin_val = quad_lookup(quad, lut_rom[quad[0] ? ~idx : idx]);

  // Sweep control.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    overrun_d = tick & busy & ~sync;
    unique case (state_q)
      S_IDLE: begin
        if (tick && !busy && !sync) begin
          state_d = S_RUN;
          ch_d    = '0;
        end
      end
      S_RUN: begin
        if (ch_q == CH_W'(NCH - 1)) begin
          state_d = S_IDLE;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (sync) begin
      state_d = S_IDLE;
    end
  end

  // Output register: the channel in stage 1 is emitted even if sync cancels the sweep.
  always_comb begin
    out_valid_d = running;
    out_ch_d    = out_ch_q;
    out_sin_d   = out_sin_q;
    out_wrap_d  = out_wrap_q;
    if (running) begin
      out_ch_d   = ch_q;
      out_sin_d  = sin_val;
      out_wrap_d = sum[PHASE_W] & ~sync;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_sin_q   <= '0;
      out_wrap_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      overrun_q   <= overrun_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      out_sin_q   <= out_sin_d;
      out_wrap_q  <= out_wrap_d;
    end
  end

  // Per-channel state. sync wins over the phase update in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        center_q[k] <= '0;
        phase_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (cfg_we && cfg_ch == CH_W'(k)) begin
          center_q[k] <= cfg_center;
        end
        if (sync) begin
          phase_q[k] <= '0;
        end else if (running && ch_q == CH_W'(k)) begin
          phase_q[k] <= sum[PHASE_W-1:0];
        end
      end
    end
  end

`ifdef NCO_COS_EN
  logic [1:0]       quad_c;
  logic [OUT_W-1:0] cos_val, out_cos_q;

  assign quad_c  = quad + 2'd1;
  assign cos_val = quad_lookup(quad_c, lut_rom[quad_c[0] ? ~idx : idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cos_q <= '0;
    end else if (running) begin
      out_cos_q <= cos_val;
    end
  end

  assign out_cos = out_cos_q;
`endif

  assign overrun   = overrun_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_sin   = out_sin_q;
  assign out_wrap  = out_wrap_q;

endmodule
